// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: power-up/CR0 init sequencer and round-robin two-master arbiter for a HyperRAM controller
module hyperram_arbiter #(
  parameter logic [15:0] INIT_WAIT  = 16'd60000,
  parameter logic [31:0] CR0_ADDR   = 32'h0000_0800,
  parameter logic [15:0] CR0_VALUE  = 16'h8F1F,
  parameter logic [2:0]  LATENCY    = 3'd7,
  parameter logic [7:0]  GAP_CYCLES = 8'd8,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [1:0]  m0_mode,
  input  logic [31:0] m0_num_words,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  output logic        m0_grant,
  output logic        m0_wr_data_next,
  output logic [31:0] m0_rd_data,
  output logic        m0_rd_valid,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic [1:0]  m1_mode,
  input  logic [31:0] m1_num_words,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  output logic        m1_grant,
  output logic        m1_wr_data_next,
  output logic [31:0] m1_rd_data,
  output logic        m1_rd_valid,
  output logic        m1_done,
  output logic        ctrl_cs,
  output logic [1:0]  ctrl_mode,
  output logic [31:0] ctrl_num_words,
  output logic [2:0]  ctrl_latency,
  output logic [31:0] ctrl_addr_in,
  output logic [31:0] ctrl_wr_data_in,
  input  logic        ctrl_wr_data_next,
  input  logic [31:0] ctrl_rd_data_out,
  input  logic        ctrl_rd_data_valid,
  output logic        init_done,
  output logic        timeout_err
);
  typedef enum logic [2:0] {PWR_WAIT, CFG_ISSUE, IDLE, ISSUE, RUN, GAP} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic [31:0] beat, nw;
  logic last_m1, err_q, pick0, hit, tmo, fin, strobe;
  assign ctrl_latency = LATENCY;
  assign ctrl_cs = state == CFG_ISSUE || state == ISSUE;
  assign strobe = ctrl_mode[0] ? ctrl_rd_data_valid : ctrl_wr_data_next;
  assign hit = state == RUN && beat == ctrl_num_words;
  assign tmo = state == RUN && !hit && cnt == TIMEOUT;
  assign fin = hit || tmo;
  assign pick0 = m0_req && (!m1_req || last_m1);
  assign nw = pick0 ? m0_num_words : m1_num_words;
  assign timeout_err = err_q || tmo;
  assign m0_done = fin && m0_grant;
  assign m1_done = fin && m1_grant;
  assign m0_wr_data_next = ctrl_wr_data_next && m0_grant;
  assign m1_wr_data_next = ctrl_wr_data_next && m1_grant;
  assign m0_rd_valid = ctrl_rd_data_valid && m0_grant;
  assign m1_rd_valid = ctrl_rd_data_valid && m1_grant;
  assign m0_rd_data = ctrl_rd_data_out;
  assign m1_rd_data = ctrl_rd_data_out;
  assign ctrl_wr_data_in = (!init_done && state != PWR_WAIT) ? {16'h0, CR0_VALUE} :
                           m0_grant ? m0_wr_data : m1_grant ? m1_wr_data : 32'h0;
  always_comb begin
    state_n = state;
    case (state)
      PWR_WAIT:         state_n = cnt == INIT_WAIT - 16'd1 ? CFG_ISSUE : PWR_WAIT;
      CFG_ISSUE, ISSUE: state_n = RUN;
      IDLE:             state_n = (m0_req || m1_req) ? ISSUE : IDLE;
      RUN:              state_n = fin ? GAP : RUN;
      GAP:              state_n = cnt == {8'h0, GAP_CYCLES} - 16'd1 ? (init_done ? IDLE : CFG_ISSUE) : GAP;
      default:          state_n = PWR_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= PWR_WAIT;
      cnt            <= '0;
      beat           <= '0;
      last_m1        <= 1'b1;
      err_q          <= 1'b0;
      init_done      <= 1'b0;
      m0_grant       <= 1'b0;
      m1_grant       <= 1'b0;
      ctrl_mode      <= '0;
      ctrl_addr_in   <= '0;
      ctrl_num_words <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 16'd1;
      beat  <= (state != RUN) ? '0 : beat + {31'h0, strobe};
      if (tmo) err_q <= 1'b1;
      if (hit && !init_done) init_done <= 1'b1;
      if (fin) begin
        m0_grant <= 1'b0;
        m1_grant <= 1'b0;
      end
      if (state == PWR_WAIT && state_n == CFG_ISSUE) begin
        ctrl_mode      <= 2'b10;
        ctrl_addr_in   <= CR0_ADDR;
        ctrl_num_words <= 32'd1;
      end
      if (state == IDLE && state_n == ISSUE) begin
        m0_grant       <= pick0;
        m1_grant       <= !pick0;
        last_m1        <= !pick0;
        ctrl_mode      <= pick0 ? m0_mode : m1_mode;
        ctrl_addr_in   <= pick0 ? m0_addr : m1_addr;
        ctrl_num_words <= (nw == 32'd0) ? 32'd1 : nw;
      end
    end
  end
endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter: directed and randomized checks of init, round-robin, timeout and async reset
module tb_hyperram_arbiter;
  localparam int IW = 10, GC = 8, TO = 50;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req = '0, grant, wnext, rvalid, done;
  logic [1:0] mode [2];
  logic [31:0] nw [2], addr [2], wdata [2];
  logic [31:0] rd0, rd1, ctrl_num_words, ctrl_addr_in, ctrl_wr_data_in, ctrl_rd_data_out;
  logic ctrl_cs, ctrl_wr_data_next, ctrl_rd_data_valid, init_done, timeout_err;
  logic [1:0] ctrl_mode;
  logic [2:0] ctrl_latency;
  int checks = 0, errors = 0, cyc = 0, last = 1, done_cyc = 0;
  bit have_done = 0;

  hyperram_arbiter #(.INIT_WAIT(16'(IW)), .GAP_CYCLES(8'(GC)), .TIMEOUT(16'(TO))) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_mode(mode[0]), .m0_num_words(nw[0]), .m0_addr(addr[0]), .m0_wr_data(wdata[0]),
    .m0_grant(grant[0]), .m0_wr_data_next(wnext[0]), .m0_rd_data(rd0), .m0_rd_valid(rvalid[0]), .m0_done(done[0]),
    .m1_req(req[1]), .m1_mode(mode[1]), .m1_num_words(nw[1]), .m1_addr(addr[1]), .m1_wr_data(wdata[1]),
    .m1_grant(grant[1]), .m1_wr_data_next(wnext[1]), .m1_rd_data(rd1), .m1_rd_valid(rvalid[1]), .m1_done(done[1]),
    .ctrl_cs(ctrl_cs), .ctrl_mode(ctrl_mode), .ctrl_num_words(ctrl_num_words), .ctrl_latency(ctrl_latency),
    .ctrl_addr_in(ctrl_addr_in), .ctrl_wr_data_in(ctrl_wr_data_in), .ctrl_wr_data_next(ctrl_wr_data_next),
    .ctrl_rd_data_out(ctrl_rd_data_out), .ctrl_rd_data_valid(ctrl_rd_data_valid),
    .init_done(init_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] oh(input int w);
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [1:0] md, input logic [31:0] n, input logic [31:0] a);
    mode[m] = md;
    nw[m] = n;
    addr[m] = a;
    wdata[m] = $urandom;
    req[m] = 1'b1;
  endtask

  task automatic wait_cs;
    int t = 0;
    while (ctrl_cs !== 1'b1 && t < 40) begin
      tick;
      t++;
    end
    chk("cs_seen", ctrl_cs, 1);
  endtask

  task automatic init_seq;
    int csb = 0, bad = 0;
    rst_n = 1'b1;
    for (int i = 1; i < IW; i++) begin
      tick;
      if (ctrl_cs) csb++;
      if (grant != 2'b00 || init_done) bad++;
    end
    chk("pwr_cs", csb, 0);
    chk("pwr_busy", bad, 0);
    tick;
    chk("cfg_cs", ctrl_cs, 1);
    chk("cfg_mode", ctrl_mode, 2'b10);
    chk("cfg_addr", ctrl_addr_in, 32'h800);
    chk("cfg_num", ctrl_num_words, 1);
    chk("cfg_wdata", ctrl_wr_data_in, 32'h0000_8F1F);
    chk("cfg_grant", grant, 0);
    repeat (2) tick;
    ctrl_wr_data_next = 1'b1;
    #1;
    chk("cfg_wnext", wnext, 0);
    tick;
    ctrl_wr_data_next = 1'b0;
    chk("cfg_fin", {init_done, grant, done}, 0);
    done_cyc = cyc;
    have_done = 1;
    last = 1;
    tick;
    chk("init_done", init_done, 1);
  endtask

  task automatic serve(input bit stall);
    int w, n;
    logic [31:0] d;
    w = (req[0] && req[1]) ? 1 - last : (req[0] ? 0 : 1);
    n = (nw[w] == 0) ? 1 : int'(nw[w]);
    wait_cs;
    if (have_done) chk("gap", cyc - done_cyc, GC + 2);
    chk("grant", grant, oh(w));
    chk("mode", ctrl_mode, mode[w]);
    chk("addr", ctrl_addr_in, addr[w]);
    chk("num", ctrl_num_words, n);
    last = w;
    if (stall) begin
      repeat (TO) tick;
      chk("pre_tmo", {timeout_err, done}, 0);
      tick;
      chk("tmo", {timeout_err, done}, {1'b1, oh(w)});
    end else begin
      tick;
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(2)) tick;
        d = $urandom;
        if (mode[w][0]) begin
          ctrl_rd_data_valid = 1'b1;
          ctrl_rd_data_out = d;
        end else ctrl_wr_data_next = 1'b1;
        #1;
        chk("early_done", done, 0);
        if (mode[w][0]) begin
          chk("rvalid", rvalid, oh(w));
          chk("rdata", (w == 0) ? rd0 : rd1, d);
        end else begin
          chk("wnext", wnext, oh(w));
          chk("wdata", ctrl_wr_data_in, wdata[w]);
        end
        tick;
        ctrl_rd_data_valid = 1'b0;
        ctrl_wr_data_next = 1'b0;
        wdata[w] = $urandom;
      end
      chk("done", done, oh(w));
    end
    done_cyc = cyc;
    have_done = 1;
    req[w] = 1'b0;
    tick;
    chk("release", {grant, done}, 0);
  endtask

  initial begin
    ctrl_wr_data_next = 1'b0;
    ctrl_rd_data_valid = 1'b0;
    ctrl_rd_data_out = '0;
    for (int m = 0; m < 2; m++) begin
      mode[m] = '0;
      nw[m] = '0;
      addr[m] = '0;
      wdata[m] = '0;
    end
    repeat (3) tick;
    chk("rst_out", {grant, done, wnext, rvalid, ctrl_cs, init_done, timeout_err}, 0);
    chk("rst_lat", ctrl_latency, 7);
    chk("rst_ctrl", ctrl_num_words | ctrl_addr_in | ctrl_wr_data_in | {30'h0, ctrl_mode}, 0);
    set_req(0, 2'b01, 4, 32'h100);
    init_seq;
    serve(0);
    set_req(1, 2'b00, 0, $urandom);
    serve(0);
    set_req(0, 2'b00, 2, $urandom);
    set_req(1, 2'b00, 2, $urandom);
    serve(0);
    set_req(0, 2'b00, 2, $urandom);
    serve(0);
    set_req(1, 2'b00, 2, $urandom);
    serve(0);
    serve(0);
    set_req(0, 2'b01, 4, $urandom);
    set_req(1, 2'b00, 1, $urandom);
    serve(1);
    serve(0);
    chk("tmo_sticky", timeout_err, 1);
    for (int i = 0; i < 12; i++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(1) == 1) set_req(m, 2'($urandom), $urandom_range(5), $urandom);
      if (req == 2'b00) set_req(int'($urandom_range(1)), 2'($urandom), $urandom_range(5), $urandom);
      serve(0);
    end
    while (req != 2'b00) serve(0);
    set_req(0, 2'b00, 3, 32'h40);
    wait_cs;
    tick;
    ctrl_wr_data_next = 1'b1;
    tick;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {grant, done, wnext, rvalid, ctrl_cs, init_done, timeout_err}, 0);
    chk("arst_ctrl", ctrl_num_words | ctrl_addr_in | ctrl_wr_data_in | {30'h0, ctrl_mode}, 0);
    chk("arst_lat", ctrl_latency, 7);
    ctrl_wr_data_next = 1'b0;
    tick;
    init_seq;
    serve(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
